conv1d_mac_sequencer: RTL and testbench



---
 rtl/conv1d_mac_sequencer.sv | 161 ++++++++++++++++
 tb/tb_conv1d_mac_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_sequencer.sv
// conv1d_mac_sequencer
// Drives the CFU conv1d MAC datapath. A start pulse launches one pass over
// KERNEL_LENGTH*depth taps. Each pass issues one read per cycle to the filter
// buffer and to the input ring buffer, and folds filter * (input + offset)
// into a 32-bit accumulator.
// Optional build macro CONV1D_MAC_SEQ_BIAS_EN adds a 'bias' input. When it is
// defined, the accumulator is seeded with bias instead of zero.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | issuing read k = 0..N-1, one per cycle
// DRAIN | absorbing the final data beat, then flagging done
module conv1d_mac_sequencer #(
  parameter int KERNEL_LENGTH      = 8,
  parameter int MAX_INPUT_CHANNELS = 128,
  parameter int ADDR_W             = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        input_depth,
  input  logic [2:0]        start_x,
  input  logic [31:0]       input_offset,
`ifdef CONV1D_MAC_SEQ_BIAS_EN
  input  logic [31:0]       bias,
`endif
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [7:0]        in_rd_data,
  output logic              flt_rd_en,
  output logic [ADDR_W-1:0] flt_rd_addr,
  input  logic [7:0]        flt_rd_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [31:0]       acc_out
);

  // One extra bit so that N = KERNEL_LENGTH*MAX_INPUT_CHANNELS is representable.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  n_q;
  logic [31:0]       off_q;
  logic [ADDR_W-1:0] in_ptr_q;
  logic [ADDR_W-1:0] flt_ptr_q;
  logic              data_vld_q;
  logic              in_rd_en_q;
  logic              flt_rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic              cfg_err_q;
  logic [31:0]       acc_q;

  logic              depth_ok;
  logic [CNT_W-1:0]  n_start;
  logic [ADDR_W-1:0] ptr_start;
  logic [CNT_W-1:0]  in_ptr_inc;
  logic [ADDR_W-1:0] in_ptr_d;
  logic              last_issue;
  logic [31:0]       acc_init;
  logic signed [31:0] flt_s;
  logic signed [31:0] in_s;
  logic signed [31:0] prod;
  logic [31:0]       acc_d;

  // Start-time decode, ring pointer stepping and MAC arithmetic.
  always_comb begin
    depth_ok   = (input_depth != 8'd0) &&
                 ({24'd0, input_depth} <= 32'(MAX_INPUT_CHANNELS));
    n_start    = CNT_W'(KERNEL_LENGTH) * CNT_W'(input_depth);
    // start_x < KERNEL_LENGTH, so this product is already below N.
    ptr_start  = ADDR_W'(start_x) * ADDR_W'(input_depth);
    in_ptr_inc = {1'b0, in_ptr_q} + CNT_W'(1);
    in_ptr_d   = (in_ptr_inc == n_q) ? '0 : in_ptr_inc[ADDR_W-1:0];
    last_issue = ({1'b0, flt_ptr_q} == (n_q - CNT_W'(1)));
`ifdef CONV1D_MAC_SEQ_BIAS_EN
    acc_init   = bias;
`else
    acc_init   = 32'd0;
`endif
    flt_s      = {{24{flt_rd_data[7]}}, flt_rd_data};
    in_s       = $signed({{24{in_rd_data[7]}}, in_rd_data}) + $signed(off_q);
    prod       = flt_s * in_s;
    acc_d      = acc_q + prod;
  end

  // Sequencer FSM with registered outputs and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      off_q       <= '0;
      in_ptr_q    <= '0;
      flt_ptr_q   <= '0;
      data_vld_q  <= 1'b0;
      in_rd_en_q  <= 1'b0;
      flt_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      // Read data lands one cycle after its enable.
      data_vld_q <= in_rd_en_q;
      if (data_vld_q) begin
        acc_q <= acc_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= acc_init;
            if (depth_ok) begin
              n_q         <= n_start;
              off_q       <= input_offset;
              in_ptr_q    <= ptr_start;
              flt_ptr_q   <= '0;
              in_rd_en_q  <= 1'b1;
              flt_rd_en_q <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              cfg_err_q   <= 1'b0;
              state_q     <= RUN;
            end else begin
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) begin
            in_rd_en_q  <= 1'b0;
            flt_rd_en_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            in_ptr_q  <= in_ptr_d;
            flt_ptr_q <= flt_ptr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rd_en    = in_rd_en_q;
  assign in_rd_addr  = in_ptr_q;
  assign flt_rd_en   = flt_rd_en_q;
  assign flt_rd_addr = flt_ptr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign acc_out     = acc_q;

endmodule

// File: tb/tb_conv1d_mac_sequencer.sv
// Self-checking bench for conv1d_mac_sequencer with byte RAM models and a
// direct-summation reference model.
module tb_conv1d_mac_sequencer;

  localparam int KL = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    input_depth;
  logic [2:0]    start_x;
  logic [31:0]   input_offset;
  logic [31:0]   bias;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [7:0]    in_rd_data;
  logic          flt_rd_en;
  logic [AW-1:0] flt_rd_addr;
  logic [7:0]    flt_rd_data;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [31:0]   acc_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] flt_mem [0:1023];
  logic [7:0] in_mem  [0:1023];

  int in_q[$];
  int flt_q[$];
  int rd_cnt = 0;
  int en_mismatch = 0;

  always #5 clk = ~clk;

  conv1d_mac_sequencer #(.KERNEL_LENGTH(8), .MAX_INPUT_CHANNELS(128), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .input_depth(input_depth),
    .start_x(start_x), .input_offset(input_offset),
`ifdef CONV1D_MAC_SEQ_BIAS_EN
    .bias(bias),
`endif
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .flt_rd_en(flt_rd_en), .flt_rd_addr(flt_rd_addr), .flt_rd_data(flt_rd_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .acc_out(acc_out)
  );

  // Synchronous byte RAMs.
  always @(posedge clk) begin
    if (in_rd_en)  in_rd_data  <= in_mem[in_rd_addr];
    if (flt_rd_en) flt_rd_data <= flt_mem[flt_rd_addr];
  end

  // Read monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (in_rd_en !== flt_rd_en) en_mismatch++;
    if (in_rd_en === 1'b1) begin
      rd_cnt++;
      in_q.push_back(int'(in_rd_addr));
      flt_q.push_back(int'(flt_rd_addr));
    end
  end

  function automatic int base_acc();
`ifdef CONV1D_MAC_SEQ_BIAS_EN
    return int'(bias);
`else
    return 0;
`endif
  endfunction

  // Reference: plain sum over taps with the ring index taken mod N.
  function automatic int model_acc(int d, int sx, int off);
    int n = KL * d;
    int acc = base_acc();
    for (int k = 0; k < n; k++) begin
      int ia = (sx * d + k) % n;
      acc += int'($signed(flt_mem[k])) * (int'($signed(in_mem[ia])) + off);
    end
    return acc;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      flt_mem[i] = 8'($urandom);
      in_mem[i]  = 8'($urandom);
    end
  endtask

  // One full run; optional second start pulse at cycle 'inject'.
  task automatic run_and_check(string name, int d, int sx, int off, int inject);
    int n = KL * d;
    int exp_acc = model_acc(d, sx, off);
    int cyc;
    int bad;
    @(negedge clk);
    in_q.delete(); flt_q.delete(); rd_cnt = 0; en_mismatch = 0;
    input_depth = 8'(d); start_x = 3'(sx); input_offset = 32'(off); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_flags busy=%b done=%b cfg_err=%b expected 1 0 0", name, busy, done, cfg_err);
    end
    while (done !== 1'b1 && cyc < 3000) begin
      start = (cyc == inject) ? 1'b1 : 1'b0;
      input_depth  = (inject != 0) ? 8'd3 : 8'($urandom);
      start_x      = 3'($urandom);
      input_offset = $urandom;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (cyc != n + 2) begin
      n_fail++;
      $display("FAIL %s done_latency got %0d expected %0d", name, cyc, n + 2);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done got %b expected 0", name, busy);
    end
    n_tests++;
    if (acc_out !== 32'(exp_acc)) begin
      n_fail++;
      $display("FAIL %s acc got %0d expected %0d", name, $signed(acc_out), exp_acc);
    end
    bad = 0;
    for (int k = 0; k < in_q.size() && k < n; k++) begin
      if (in_q[k] != (sx * d + k) % n || flt_q[k] != k) bad++;
    end
    n_tests++;
    if (rd_cnt != n || bad != 0 || en_mismatch != 0) begin
      n_fail++;
      $display("FAIL %s reads got count=%0d badaddr=%0d enmis=%0d expected count=%0d 0 0",
               name, rd_cnt, bad, en_mismatch, n);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (acc_out !== 32'(exp_acc) || done !== 1'b1 || rd_cnt != n) begin
      n_fail++;
      $display("FAIL %s idle_stable acc=%0d done=%b reads=%0d expected %0d 1 %0d",
               name, $signed(acc_out), done, rd_cnt, exp_acc, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; input_depth = 8'd0; start_x = 3'd0;
    input_offset = 32'd0; bias = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || acc_out !== 32'd0 ||
        in_rd_en !== 1'b0 || flt_rd_en !== 1'b0 || in_rd_addr !== '0 || flt_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b err=%b acc=%0d en=%b%b addr=%0d/%0d expected all 0",
               busy, done, cfg_err, acc_out, in_rd_en, flt_rd_en, in_rd_addr, flt_rd_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 1024; i++) begin flt_mem[i] = 8'd1; in_mem[i] = 8'd0; end
    for (int i = 0; i < 8; i++) in_mem[i] = 8'(i + 1);
    run_and_check("d1_sum", 1, 0, 0, 0);
    n_tests++;
    if (acc_out !== 32'(36 + base_acc())) begin
      n_fail++;
      $display("FAIL d1_literal acc got %0d expected %0d", $signed(acc_out), 36 + base_acc());
    end
    for (int i = 0; i < 1024; i++) begin flt_mem[i] = 8'd2; in_mem[i] = 8'hFF; end
    run_and_check("d2_wrap", 2, 7, -128, 0);
    n_tests++;
    if (acc_out !== 32'(-4128 + base_acc())) begin
      n_fail++;
      $display("FAIL d2_literal acc got %0d expected %0d", $signed(acc_out), -4128 + base_acc());
    end
  endtask

  task automatic test_start_while_busy();
    fill_random();
    run_and_check("busy_start", 1, 3, 17, 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int d = (r == 0) ? 128 : int'($urandom_range(1, 128));
      int sx = int'($urandom_range(0, 7));
      int off = int'($urandom);
      fill_random();
      bias = $urandom;
      run_and_check($sformatf("rand%0d", r), d, sx, off, 0);
    end
    bias = 32'd0;
  endtask

  task automatic test_reset_midrun();
    int cnt0;
    fill_random();
    @(negedge clk);
    input_depth = 8'd4; start_x = 3'd1; input_offset = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cnt0 = rd_cnt;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || acc_out !== 32'd0 || in_rd_en !== 1'b0 ||
        flt_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset busy=%b done=%b acc=%0d en=%b%b expected all 0",
               busy, done, $signed(acc_out), in_rd_en, flt_rd_en);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_cnt != cnt0) begin
      n_fail++;
      $display("FAIL midrun_no_reads got %0d expected %0d", rd_cnt - cnt0, 0);
    end
    run_and_check("after_reset", 4, 6, -3, 0);
  endtask

  task automatic test_illegal_depth();
    int depths[3] = '{0, 129, 255};
    for (int i = 0; i < 3; i++) begin
      int cnt0;
      @(negedge clk);
      bias = 32'(100 * i);
      cnt0 = rd_cnt;
      input_depth = 8'(depths[i]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0 || acc_out !== 32'(base_acc())) begin
        n_fail++;
        $display("FAIL illegal_%0d done=%b err=%b busy=%b acc=%0d expected 1 1 0 %0d",
                 depths[i], done, cfg_err, busy, $signed(acc_out), base_acc());
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (rd_cnt != cnt0 || cfg_err !== 1'b1 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_hold_%0d reads=%0d err=%b done=%b expected 0 1 1",
                 depths[i], rd_cnt - cnt0, cfg_err, done);
      end
    end
    bias = 32'd0;
    fill_random();
    run_and_check("legal_clears_err", 1, 5, 9, 0);
  endtask

  task automatic test_bias();
`ifdef CONV1D_MAC_SEQ_BIAS_EN
    for (int i = 0; i < 1024; i++) begin flt_mem[i] = 8'd1; in_mem[i] = 8'd1; end
    bias = 32'd1000;
    run_and_check("bias", 1, 0, 0, 0);
    n_tests++;
    if (acc_out !== 32'd1008) begin
      n_fail++;
      $display("FAIL bias_literal acc got %0d expected 1008", $signed(acc_out));
    end
    bias = 32'd0;
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_midrun();
    test_illegal_depth();
    test_random();
    test_bias();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
